mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the two-master memory arbiter.
//   state_t  - arbiter FSM encoding (IDLE, XFER, DONE)
//   ADDR_W   - memory word address width
//   DATA_W   - memory data width
//   CNT_W    - per-master completed-access counter width
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the two-master arbiter.
// Ports:
//   m0_req, m1_req  - current master requests
//   last_winner     - master that completed the previous access (0 or 1)
//   any_req         - at least one master is requesting
//   pick_m1         - 1 when master 1 wins, 0 when master 0 wins
// Parameter FIXED_PRIO: 0 = round-robin, 1 = master 0 always wins.
module mem_arb_pick #(
    parameter int FIXED_PRIO = 0
) (
    input  logic m0_req,
    input  logic m1_req,
    input  logic last_winner,
    output logic any_req,
    output logic pick_m1
);

    always_comb begin
        any_req = m0_req | m1_req;
        pick_m1 = 1'b0;
        if (FIXED_PRIO != 0) begin
            pick_m1 = ~m0_req;
        end else if (m0_req && m1_req) begin
            // Tie: the master that did not win last time goes next.
            pick_m1 = ~last_winner;
        end else begin
            pick_m1 = m1_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two masters onto one shared single-cycle memory.
//
// Handshake: a master raises mN_req with mN_we/mN_addr/mN_wdata stable and
// holds it until mN_ack. mN_ack is a one-cycle pulse; mN_rdata is valid only
// while mN_ack is high and is zero otherwise. A req still high after the ack
// is treated as a new request in the next IDLE cycle.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   m0_* / m1_*             - master request/ack interfaces
//   mem_addr/we/wdata       - shared memory drive, nonzero only in XFER
//   mem_rdata               - shared memory read data (combinational)
//   grant_cnt0/1            - saturating completed-access counters
//   state_dbg               - current FSM state for observation
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output state_t            state_dbg
);

    state_t             state_q, state_d;
    logic               winner_q;
    logic               last_winner_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [CNT_W-1:0]   cnt0_q, cnt1_q;
    logic               any_req;
    logic               pick_m1;

    mem_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .last_winner (last_winner_q),
        .any_req     (any_req),
        .pick_m1     (pick_m1)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = XFER;
            XFER:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are latched at the arbitration point so that later
    // changes on either master cannot disturb the access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            winner_q      <= 1'b0;
            last_winner_q <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            cnt0_q        <= '0;
            cnt1_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        winner_q <= pick_m1;
                        we_q     <= pick_m1 ? m1_we    : m0_we;
                        addr_q   <= pick_m1 ? m1_addr  : m0_addr;
                        wdata_q  <= pick_m1 ? m1_wdata : m0_wdata;
                    end
                end
                XFER: begin
                    rdata_q <= mem_rdata;
                end
                DONE: begin
                    last_winner_q <= winner_q;
                    if (!winner_q && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_W'(1);
                    if (winner_q && cnt1_q != CNT_MAX)  cnt1_q <= cnt1_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state so that an asynchronous reset clears
    // the memory strobe and acks in the same cycle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        m0_ack    = 1'b0;
        m0_rdata  = '0;
        m1_ack    = 1'b0;
        m1_rdata  = '0;
        case (state_q)
            XFER: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = wdata_q;
            end
            DONE: begin
                if (winner_q) begin
                    m1_ack   = 1'b1;
                    m1_rdata = rdata_q;
                end else begin
                    m0_ack   = 1'b1;
                    m0_rdata = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
    assign state_dbg  = state_q;

endmodule
